// File: rtl/risc16_pkg.sv
// risc16_pkg: shared widths and fetch FSM encoding
// for the RiSC-16 core.
package risc16_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_ISSUE,
    FS_WAIT,
    FS_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_counter.sv
// fetch_wait_counter: loadable 2-bit down-counter
// whose zero flag ends the fetch WAIT phase.
module fetch_wait_counter (
  input  logic       clk0,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RiSC-16 fetch stage with wait-state
// memory access, instruction register and redirect.
module instr_fetch_unit #(
  parameter int ADDR_W  = risc16_pkg::ADDR_W,
  parameter int INSTR_W = risc16_pkg::INSTR_W
) (
  input  logic               clk0,
  input  logic               reset,
  input  logic [1:0]         wait_cycle,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               dec_ready,
  output logic [ADDR_W-1:0]  pc_next
);

  import risc16_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               squash_q, squash_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic               hs;

  fetch_wait_counter u_wait_cnt (
    .clk0     (clk0),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (wait_cycle),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign hs = (state_q == FS_HOLD) && dec_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    squash_d   = squash_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        state_d = FS_ISSUE;
      end
      FS_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = FS_WAIT;
        if (redirect) squash_d = 1'b1;
      end
      FS_WAIT: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
          if (redirect) squash_d = 1'b1;
        // a redirect on the last wait cycle drops the data too
        end else if (squash_q || redirect) begin
          squash_d = 1'b0;
          state_d  = FS_ISSUE;
        end else begin
          instr_d    = mem_rdata;
          instr_pc_d = fetch_pc_q;
          valid_d    = 1'b1;
          state_d    = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (hs || redirect) begin
          valid_d = 1'b0;
          state_d = FS_ISSUE;
        end
        if (hs) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
    endcase
    if (redirect && state_q != FS_IDLE) begin
      fetch_pc_d = redirect_addr;
    end
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= '0;
      squash_q   <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      squash_q   <= squash_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_en      = (state_q == FS_ISSUE);
  assign mem_addr    = fetch_pc_q;
  assign pc_next     = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random fetch
// scenarios against a cycle-timeline reference model.
module tb_instr_fetch_unit;

  logic        clk0 = 1'b0;
  logic        reset;
  logic [1:0]  wait_cycle;
  logic        mem_en;
  logic [5:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [5:0]  redirect_addr;
  logic [15:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic [5:0]  pc_next;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk0          (clk0),
    .reset         (reset),
    .wait_cycle    (wait_cycle),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .dec_ready     (dec_ready),
    .pc_next       (pc_next)
  );

  always #5 clk0 = ~clk0;

  // memory: data valid W+1 cycles after the pulse, junk before
  logic [15:0] mem [64];
  logic [5:0]  rd_addr = 6'd0;
  logic [1:0]  rd_dly = 2'd0;
  logic        rd_ok = 1'b0;

  always @(posedge clk0) begin
    if (mem_en) begin
      rd_addr <= mem_addr;
      rd_dly  <= wait_cycle;
      rd_ok   <= 1'b1;
    end else if (rd_dly != 2'd0) begin
      rd_dly <= rd_dly - 2'd1;
    end
  end

  assign mem_rdata = (rd_ok && rd_dly == 2'd0)
                   ? mem[rd_addr]
                   : (~mem[rd_addr] ^ 16'h5A5A);

  // reference model state
  int          cyc;
  int          next_issue;
  logic [5:0]  m_pc;
  logic        m_held;
  logic [5:0]  m_ipc;
  logic [15:0] m_instr;
  logic        m_out;
  logic [5:0]  m_oaddr;
  int          m_ow;
  int          m_oiss;
  logic        m_osq;
  int          n_hs;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    next_issue = 1;
    m_pc       = 6'd0;
    m_held     = 1'b0;
    m_out      = 1'b0;
    m_osq      = 1'b0;
  endtask

  // check this cycle, advance the model, move to next negedge
  task automatic step();
    logic exp_en;
    logic hs;
    exp_en = (cyc == next_issue);
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_held));
    if (m_held) begin
      chk("instr", 32'(instr), 32'(m_instr));
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    end
    chk("pc_next", 32'(pc_next), 32'(m_pc));
    if (instr_valid && dec_ready) n_hs++;
    if (exp_en) begin
      m_out   = 1'b1;
      m_oaddr = m_pc;
      m_ow    = int'(wait_cycle);
      m_oiss  = cyc;
      m_osq   = 1'b0;
    end
    if (m_out && redirect) m_osq = 1'b1;
    hs = m_held && dec_ready;
    if (m_held && (dec_ready || redirect)) begin
      m_held     = 1'b0;
      next_issue = cyc + 1;
    end
    if (m_out && cyc == m_oiss + 1 + m_ow) begin
      m_out = 1'b0;
      if (m_osq) begin
        next_issue = cyc + 1;
      end else begin
        m_held  = 1'b1;
        m_ipc   = m_oaddr;
        m_instr = mem[m_oaddr];
      end
    end
    if (redirect && cyc != 0) m_pc = redirect_addr;
    else if (hs) m_pc = m_pc + 6'd1;
    cyc++;
    @(posedge clk0);
    @(negedge clk0);
  endtask

  task automatic redir(logic [5:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    step();
    redirect      = 1'b0;
  endtask

  task automatic wait_issue(string tag);
    int n;
    n = 0;
    while (next_issue != cyc && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(next_issue == cyc), 32'd1);
  endtask

  task automatic wait_held(string tag);
    int n;
    n = 0;
    while (!m_held && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(m_held), 32'd1);
  endtask

  initial begin
    logic [15:0] saved;
    logic [5:0]  seq [3];
    int          got;
    int          hs0;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[0]        = 16'h1234;
    reset         = 1'b0;
    wait_cycle    = 2'd0;
    redirect      = 1'b0;
    redirect_addr = 6'd0;
    dec_ready     = 1'b0;
    n_hs          = 0;
    model_reset();
    repeat (3) @(negedge clk0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    reset = 1'b1;

    // basic fetch, W=0
    dec_ready = 1'b1;
    step();
    chk("t1_mem_en_c1", 32'(mem_en), 32'd1);
    step();
    step();
    chk("t1_instr", 32'(instr), 32'h1234);
    chk("t1_instr_pc", 32'(instr_pc), 32'd0);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    step();
    chk("t1_pc_next", 32'(pc_next), 32'd1);

    // W=3 stall; this cycle is ISSUE of address 1
    wait_cycle = 2'd3;
    dec_ready  = 1'b0;
    chk("t2_issue", 32'(mem_en), 32'd1);
    repeat (5) step();
    chk("t2_rise", 32'(instr_valid), 32'd1);
    saved = instr;
    repeat (10) begin
      wait_cycle = 2'($urandom);
      step();
    end
    chk("t2_stable", 32'(instr), 32'(saved));
    hs0       = n_hs;
    dec_ready = 1'b1;
    step();
    chk("t2_next_issue", 32'(mem_en), 32'd1);
    step();
    chk("t2_one_hs", 32'(n_hs - hs0), 32'd1);
    dec_ready = 1'b0;

    // sequential wrap from 62
    wait_cycle = 2'd0;
    dec_ready  = 1'b1;
    redir(6'd62);
    got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (instr_valid) begin
        seq[got] = instr_pc;
        got++;
      end
      step();
    end
    chk("t3_count", 32'(got), 32'd3);
    chk("t3_pc0", 32'(seq[0]), 32'd62);
    chk("t3_pc1", 32'(seq[1]), 32'd63);
    chk("t3_pc2", 32'(seq[2]), 32'd0);

    // redirect during WAIT of address 5
    dec_ready  = 1'b1;
    wait_cycle = 2'd2;
    redir(6'd5);
    wait_issue("t4_to_issue5");
    chk("t4_addr5", 32'(mem_addr), 32'd5);
    step();
    redir(6'h20);
    for (int i = 0; i < 20 && next_issue != cyc; i++) begin
      chk("t4_no_valid", 32'(instr_valid), 32'd0);
      step();
    end
    chk("t4_reissue", 32'(mem_en), 32'd1);
    chk("t4_addr20", 32'(mem_addr), 32'h20);
    dec_ready = 1'b0;
    wait_held("t4_deliver");
    chk("t4_instr_pc", 32'(instr_pc), 32'h20);

    // redirect coincident with handshake of pc 7
    dec_ready  = 1'b1;
    wait_cycle = 2'd1;
    redir(6'd7);
    dec_ready = 1'b0;
    wait_held("t5_held");
    chk("t5_instr_pc", 32'(instr_pc), 32'd7);
    hs0       = n_hs;
    dec_ready = 1'b1;
    redir(6'h10);
    dec_ready = 1'b0;
    chk("t5_hs", 32'(n_hs - hs0), 32'd1);
    chk("t5_pc_next", 32'(pc_next), 32'h10);
    wait_issue("t5_to_issue");
    chk("t5_addr", 32'(mem_addr), 32'h10);

    // async reset during WAIT
    wait_cycle = 2'd3;
    dec_ready  = 1'b1;
    redir(6'h2A);
    wait_issue("t6_to_issue");
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_mem_en", 32'(mem_en), 32'd0);
    chk("t6_pc_next", 32'(pc_next), 32'd0);
    chk("t6_instr_pc", 32'(instr_pc), 32'd0);
    @(negedge clk0);
    reset = 1'b1;
    model_reset();
    dec_ready = 1'b0;
    wait_held("t6_refetch");
    chk("t6_addr0", 32'(instr_pc), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      dec_ready     = 1'($urandom_range(0, 1));
      wait_cycle    = 2'($urandom_range(0, 3));
      redirect      = ($urandom_range(0, 7) == 0);
      redirect_addr = 6'($urandom);
      step();
    end
    redirect = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
